// File: rtl/wb_disp_sched_pkg.sv
// Shared types for the writeback display scheduler: FSM encoding and FIFO entry layout.
package wb_disp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int ENTRY_W = 19;

    typedef struct packed {
        logic [2:0]  dr;
        logic [15:0] val;
    } entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; caller qualifies push/pop, so push+pop when full is legal.
module wb_fifo
    import wb_disp_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [ENTRY_W-1:0]       wdata_i,
    output logic [ENTRY_W-1:0]       rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // power-of-two depth: pointers wrap on natural overflow
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_i && !pop_i)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!push_i && pop_i) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/wb_disp_sched.sv
// Writeback display scheduler: queues writebacks and shows each on the 7-seg bus for a hold time,
// with freeze/single-step for board debug.
module wb_disp_sched
    import wb_disp_sched_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 25000000,
    parameter int CW          = 25
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WB_EN,
    input  logic [2:0]  DR,
    input  logic [15:0] WB_VAL,
    input  logic        FREEZE,
    input  logic        STEP,
    output logic [15:0] DISP_VAL,
    output logic [2:0]  DISP_DR,
    output logic        DISP_VALID,
    output logic        FULL,
    output logic [7:0]  DROP_CNT
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    entry_t          disp_q;
    logic            vld_q;
    logic [7:0]      drop_q;

    logic            pop, push, drop, hold_done;
    logic            fifo_full, fifo_empty;
    logic [CNTW-1:0] fifo_cnt;
    entry_t          head, wentry;

    assign wentry    = '{dr: DR, val: WB_VAL};
    assign hold_done = (cnt_q == CW'(HOLD_CYCLES - 1));
    // a pop frees a slot in the same cycle, so a full FIFO can still accept
    assign push      = WB_EN && (!fifo_full || pop);
    assign drop      = WB_EN && fifo_full && !pop;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (FREEZE) state_d = PAUSE;
                     else if (!fifo_empty) state_d = SHOW;
            SHOW:    if (FREEZE) state_d = PAUSE;
                     else if (hold_done && fifo_empty) state_d = IDLE;
            PAUSE:   if (!FREEZE) state_d = vld_q ? SHOW : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FREEZE outranks STEP only when leaving PAUSE
    always_comb begin
        pop   = 1'b0;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (!FREEZE && !fifo_empty) begin
                pop   = 1'b1;
                cnt_d = '0;
            end
            SHOW: if (!FREEZE) begin
                if (hold_done) begin
                    pop   = !fifo_empty;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAUSE: if (!FREEZE) cnt_d = '0;
                   else if (STEP && !fifo_empty) pop = 1'b1;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            disp_q <= '0;
            vld_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (pop) begin
                disp_q <= head;
                vld_q  <= 1'b1;
            end
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign DISP_VAL   = disp_q.val;
    assign DISP_DR    = disp_q.dr;
    assign DISP_VALID = vld_q;
    assign FULL       = (fifo_cnt == CNTW'(DEPTH));
    assign DROP_CNT   = drop_q;

endmodule

// File: tb/tb_wb_disp_sched.sv
// Directed bench for wb_disp_sched with DEPTH=4, HOLD_CYCLES=4: vector table plus freeze/reset/saturation sequences.
module tb_wb_disp_sched;

    logic        CLK = 1'b0, RST = 1'b1, WB_EN = 1'b0, FREEZE = 1'b0, STEP = 1'b0;
    logic [2:0]  DR = '0;
    logic [15:0] WB_VAL = '0;
    logic [15:0] DISP_VAL;
    logic [2:0]  DISP_DR;
    logic        DISP_VALID, FULL;
    logic [7:0]  DROP_CNT;

    int n_vec = 0;
    int n_err = 0;

    wb_disp_sched #(.DEPTH(4), .HOLD_CYCLES(4), .CW(3)) dut (
        .CLK(CLK), .RST(RST), .WB_EN(WB_EN), .DR(DR), .WB_VAL(WB_VAL),
        .FREEZE(FREEZE), .STEP(STEP), .DISP_VAL(DISP_VAL), .DISP_DR(DISP_DR),
        .DISP_VALID(DISP_VALID), .FULL(FULL), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, wb, fz, st;
        logic [2:0]  dr;
        logic [15:0] val;
        logic [15:0] e_v;
        logic [2:0]  e_dr;
        logic        e_vl, e_f;
        logic [7:0]  e_d;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int n, logic rst, logic wb, logic [2:0] dr, logic [15:0] val,
                                logic fz, logic st, logic [15:0] e_v, logic [2:0] e_dr,
                                logic e_vl, logic e_f, logic [7:0] e_d);
        vec_t r;
        r.rst = rst; r.wb = wb; r.dr = dr; r.val = val; r.fz = fz; r.st = st;
        r.e_v = e_v; r.e_dr = e_dr; r.e_vl = e_vl; r.e_f = e_f; r.e_d = e_d;
        for (int k = 0; k < n; k++) tbl.push_back(r);
    endfunction

    // one clock: drive on the falling edge, sample 1ns after the rising edge
    task automatic cyc(input logic rst, input logic wb, input logic [2:0] dr,
                       input logic [15:0] val, input logic fz, input logic st);
        @(negedge CLK);
        RST = rst; WB_EN = wb; DR = dr; WB_VAL = val; FREEZE = fz; STEP = st;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] e_v, input logic [2:0] e_dr,
                       input logic e_vl, input logic e_f, input logic [7:0] e_d);
        n_vec++;
        if ({DISP_VAL, DISP_DR, DISP_VALID, FULL, DROP_CNT} !== {e_v, e_dr, e_vl, e_f, e_d}) begin
            n_err++;
            $display("FAIL %s: got val=%h dr=%0d vld=%b full=%b drop=%0d, expected val=%h dr=%0d vld=%b full=%b drop=%0d",
                     nm, DISP_VAL, DISP_DR, DISP_VALID, FULL, DROP_CNT, e_v, e_dr, e_vl, e_f, e_d);
        end
    endtask

    initial begin
        //  n  rst wb dr  val        fz st   e_val     e_dr vl f  drop
        // reset, single write, hold then back to IDLE
        add(1, 1, 0, 0, 16'h0000, 0, 0,  16'h0000, 0, 0, 0, 0);
        add(1, 0, 1, 3, 16'h1234, 0, 0,  16'h0000, 0, 0, 0, 0);
        add(5, 0, 0, 0, 16'h0000, 0, 0,  16'h1234, 3, 1, 0, 0);
        // three-write burst, each held 4 cycles
        add(1, 0, 1, 1, 16'h0001, 0, 0,  16'h1234, 3, 1, 0, 0);
        add(1, 0, 1, 2, 16'h0002, 0, 0,  16'h0001, 1, 1, 0, 0);
        add(1, 0, 1, 3, 16'h0003, 0, 0,  16'h0001, 1, 1, 0, 0);
        add(2, 0, 0, 0, 16'h0000, 0, 0,  16'h0001, 1, 1, 0, 0);
        add(4, 0, 0, 0, 16'h0000, 0, 0,  16'h0002, 2, 1, 0, 0);
        add(5, 0, 0, 0, 16'h0000, 0, 0,  16'h0003, 3, 1, 0, 0);
        // six writes during a hold: A5 overflows
        add(1, 0, 1, 5, 16'h00E0, 0, 0,  16'h0003, 3, 1, 0, 0);
        add(1, 0, 0, 0, 16'h0000, 0, 0,  16'h00E0, 5, 1, 0, 0);
        add(1, 0, 1, 0, 16'h00A0, 0, 0,  16'h00E0, 5, 1, 0, 0);
        add(1, 0, 1, 1, 16'h00A1, 0, 0,  16'h00E0, 5, 1, 0, 0);
        add(1, 0, 1, 2, 16'h00A2, 0, 0,  16'h00E0, 5, 1, 0, 0);
        add(1, 0, 1, 3, 16'h00A3, 0, 0,  16'h00A0, 0, 1, 0, 0);
        add(1, 0, 1, 4, 16'h00A4, 0, 0,  16'h00A0, 0, 1, 1, 0);
        add(1, 0, 1, 5, 16'h00A5, 0, 0,  16'h00A0, 0, 1, 1, 1);
        add(1, 0, 0, 0, 16'h0000, 0, 0,  16'h00A0, 0, 1, 1, 1);
        add(4, 0, 0, 0, 16'h0000, 0, 0,  16'h00A1, 1, 1, 0, 1);
        add(4, 0, 0, 0, 16'h0000, 0, 0,  16'h00A2, 2, 1, 0, 1);
        add(4, 0, 0, 0, 16'h0000, 0, 0,  16'h00A3, 3, 1, 0, 1);
        add(5, 0, 0, 0, 16'h0000, 0, 0,  16'h00A4, 4, 1, 0, 1);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].wb, tbl[i].dr, tbl[i].val, tbl[i].fz, tbl[i].st);
            chk($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_dr, tbl[i].e_vl, tbl[i].e_f, tbl[i].e_d);
        end

        // freeze while showing BEEF with two queued, then single-step
        cyc(0, 1, 7, 16'hBEEF, 0, 0); chk("frz_load0", 16'h00A4, 4, 1, 0, 1);
        cyc(0, 1, 1, 16'hC001, 0, 0); chk("frz_load1", 16'hBEEF, 7, 1, 0, 1);
        cyc(0, 1, 2, 16'hC002, 0, 0); chk("frz_load2", 16'hBEEF, 7, 1, 0, 1);
        for (int k = 0; k < 20; k++) begin
            cyc(0, 0, 0, 16'h0, 1, 0); chk($sformatf("frz_hold%0d", k), 16'hBEEF, 7, 1, 0, 1);
        end
        cyc(0, 0, 0, 16'h0, 1, 1); chk("step1", 16'hC001, 1, 1, 0, 1);
        cyc(0, 0, 0, 16'h0, 1, 0); chk("step1_gap", 16'hC001, 1, 1, 0, 1);
        cyc(0, 0, 0, 16'h0, 1, 1); chk("step2", 16'hC002, 2, 1, 0, 1);
        cyc(0, 0, 0, 16'h0, 1, 0); chk("step2_gap", 16'hC002, 2, 1, 0, 1);
        cyc(0, 0, 0, 16'h0, 1, 1); chk("step3_empty", 16'hC002, 2, 1, 0, 1);
        cyc(0, 1, 3, 16'hC003, 1, 0); chk("frz_capture", 16'hC002, 2, 1, 0, 1);
        // release with STEP high: leaves PAUSE without popping, full hold follows
        cyc(0, 0, 0, 16'h0, 0, 1); chk("release", 16'hC002, 2, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 16'h0, 0, 0); chk($sformatf("rel_hold%0d", k), 16'hC002, 2, 1, 0, 1);
        end
        cyc(0, 0, 0, 16'h0, 0, 0); chk("rel_pop", 16'hC003, 3, 1, 0, 1);

        // reset mid-hold with three queued, write in the same cycle is ignored
        cyc(0, 1, 4, 16'hD001, 0, 0); chk("rq0", 16'hC003, 3, 1, 0, 1);
        cyc(0, 1, 5, 16'hD002, 0, 0); chk("rq1", 16'hC003, 3, 1, 0, 1);
        cyc(0, 1, 6, 16'hD003, 0, 0); chk("rq2", 16'hC003, 3, 1, 0, 1);
        cyc(1, 1, 7, 16'hD004, 0, 0); chk("rst_mid", 16'h0000, 0, 0, 0, 0);
        cyc(0, 0, 0, 16'h0, 0, 0);    chk("rst_empty", 16'h0000, 0, 0, 0, 0);
        cyc(0, 1, 0, 16'h00FF, 0, 0); chk("post_push", 16'h0000, 0, 0, 0, 0);
        cyc(0, 0, 0, 16'h0, 0, 0);    chk("post_show", 16'h00FF, 0, 1, 0, 0);

        // drop counter saturation while frozen
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 16'h5555, 1, 0);
        chk("drop_first", 16'h00FF, 0, 1, 1, 1);
        for (int k = 0; k < 255; k++) cyc(0, 1, 1, 16'h5555, 1, 0);
        chk("drop_sat", 16'h00FF, 0, 1, 1, 8'hFF);
        cyc(1, 1, 1, 16'h5555, 1, 1); chk("rst_frozen", 16'h0000, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
